display_mode_ctrl: RTL and testbench

Sequencer for the calculator's display-source multiplexing. It debounces the mode pushbutton and steps the display among operand A, operand B and result. When the ALU signals a new result, it latches that result and forces a timed result display. It drives the 2-bit source select, the one-hot mode LEDs and a registered 32-bit display word, and sits between the keypad/ALU and the seven-segment decoders.

---
 rtl/display_mode_ctrl_if.sv | 28 ++
 rtl/display_mode_ctrl.sv | 138 +++++++++++++
 tb/tb_display_mode_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/display_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : display_mode_ctrl_if
// Purpose  : Keypad/ALU-side inputs and display-side outputs of the mode sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface display_mode_ctrl_if;
  logic        key_mode;
  logic        res_valid;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [31:0] data3;
  logic [1:0]  sel;
  logic [2:0]  led;
  logic [31:0] out;
  logic        hold_active;

  modport master (
    output key_mode, res_valid, data1, data2, data3,
    input  sel, led, out, hold_active
  );

  modport slave (
    input  key_mode, res_valid, data1, data2, data3,
    output sel, led, out, hold_active
  );
endinterface
`default_nettype wire

// File: rtl/display_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_mode_ctrl
// Purpose  : Debounced mode key steps the display A -> B -> result; ALU results
//            force a timed result display before returning to the prior view.
// Revision : 1.0  initial release
// ============================================================================
module display_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 150000000
) (
  input  logic              clk,
  input  logic              rst_n,
  display_mode_ctrl_if.slave bus
);

  localparam int c_db_w   = $clog2(DEBOUNCE_CYCLES);
  localparam int c_hold_w = $clog2(HOLD_CYCLES);
  localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    SHOW_A   = 2'b00,
    SHOW_B   = 2'b01,
    SHOW_RES = 2'b10,
    HOLD     = 2'b11
  } state_t;

  logic [1:0]          r_sync;
  logic                r_key_db;
  logic [c_db_w-1:0]   r_db_cnt;
  logic                r_press;

  state_t              r_state, w_state_nxt;
  state_t              r_saved, w_saved_nxt;
  logic [c_hold_w-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [31:0]         r_result;
  logic [31:0]         r_out;

  logic [1:0]          w_sel;
  logic [2:0]          w_led;
  logic                w_hold;

  // Any disagreement that does not persist for the full window restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_key_db <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], bus.key_mode};
      r_press <= 1'b0;
      if (r_sync[1] != r_key_db) begin
        if (r_db_cnt == c_db_last) begin
          r_key_db <= r_sync[1];
          r_db_cnt <= '0;
          r_press  <= r_key_db;
        end else begin
          r_db_cnt <= r_db_cnt + c_db_w'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= SHOW_A;
      r_saved    <= SHOW_A;
      r_hold_cnt <= '0;
      r_result   <= '0;
      r_out      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_saved    <= w_saved_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      if (bus.res_valid) begin
        r_result <= bus.data3;
      end
      case (w_sel)
        2'b00:   r_out <= {16'h0000, bus.data1};
        2'b01:   r_out <= {16'h0000, bus.data2};
        default: r_out <= r_result;
      endcase
    end
  end

  // A result pulse outranks a simultaneous key press; a retrigger keeps the
  // originally saved view.
  always_comb begin
    w_state_nxt    = r_state;
    w_saved_nxt    = r_saved;
    w_hold_cnt_nxt = r_hold_cnt;
    if (bus.res_valid) begin
      w_state_nxt    = HOLD;
      w_hold_cnt_nxt = '0;
      if (r_state != HOLD) begin
        w_saved_nxt = r_state;
      end
    end else begin
      case (r_state)
        SHOW_A:   if (r_press) w_state_nxt = SHOW_B;
        SHOW_B:   if (r_press) w_state_nxt = SHOW_RES;
        SHOW_RES: if (r_press) w_state_nxt = SHOW_A;
        HOLD: begin
          if (r_press || (r_hold_cnt == c_hold_last)) begin
            w_state_nxt = r_saved;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + c_hold_w'(1);
          end
        end
        default:  w_state_nxt = SHOW_A;
      endcase
    end
  end

  always_comb begin
    w_sel  = 2'b00;
    w_led  = 3'b001;
    w_hold = 1'b0;
    case (r_state)
      SHOW_A:   begin w_sel = 2'b00; w_led = 3'b001; end
      SHOW_B:   begin w_sel = 2'b01; w_led = 3'b010; end
      SHOW_RES: begin w_sel = 2'b10; w_led = 3'b100; end
      HOLD:     begin w_sel = 2'b10; w_led = 3'b100; w_hold = 1'b1; end
      default:  begin w_sel = 2'b00; w_led = 3'b001; end
    endcase
  end

  assign bus.sel         = w_sel;
  assign bus.led         = w_led;
  assign bus.out         = r_out;
  assign bus.hold_active = w_hold;

endmodule
`default_nettype wire

// File: tb/tb_display_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_mode_ctrl
// Purpose  : Directed and random stimulus for display_mode_ctrl against a
//            view-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_display_mode_ctrl;

  localparam int DB = 4;
  localparam int HC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_mode_ctrl_if dif ();

  display_mode_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: view 0=A, 1=B, 2=result, 3=forced result display.
  int          m_view  = 0;
  int          m_saved = 0;
  int          m_left  = 0;
  int          m_run   = 0;
  bit          m_level = 1'b1;
  bit          m_press = 1'b0;
  bit          m_hist[$];
  logic [31:0] m_result = '0;
  logic [31:0] m_out = '0;

  function automatic int shown(input int v);
    return (v == 3) ? 2 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit s;
    bit p;
    if (!rst_n) begin
      m_view = 0; m_saved = 0; m_left = 0; m_run = 0;
      m_level = 1'b1; m_press = 1'b0; m_result = '0; m_out = '0;
      m_hist = '{1'b1, 1'b1};
    end else begin
      case (shown(m_view))
        0:       m_out = {16'h0000, dif.data1};
        1:       m_out = {16'h0000, dif.data2};
        default: m_out = m_result;
      endcase
      p = m_press;
      s = m_hist.pop_front();
      m_hist.push_back(dif.key_mode);
      m_press = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == DB) begin
          m_level = s;
          m_run   = 0;
          m_press = (s == 1'b0);
        end
      end else begin
        m_run = 0;
      end
      if (dif.res_valid) begin
        if (m_view != 3) m_saved = m_view;
        m_view   = 3;
        m_left   = HC - 1;
        m_result = dif.data3;
      end else if (m_view == 3) begin
        if (p || m_left == 0) m_view = m_saved;
        else m_left--;
      end else if (p) begin
        m_view = (m_view + 1) % 3;
      end
    end
  endtask

  task automatic tick();
    int sv;
    @(posedge clk);
    model_edge();
    #1;
    sv = shown(m_view);
    chk("sel",  32'(dif.sel), 32'(sv));
    chk("led",  32'(dif.led), 32'(1 << sv));
    chk("out",  dif.out, m_out);
    chk("hold", 32'(dif.hold_active), 32'(m_view == 3));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int low, input int high);
    dif.key_mode = 1'b0;
    ticks(low);
    dif.key_mode = 1'b1;
    ticks(high);
  endtask

  initial begin
    logic [1:0] seq [3];
    int k;
    int hold_len;
    seq = '{2'd1, 2'd2, 2'd0};

    // Reset with random inputs
    dif.key_mode  = 1'($urandom);
    dif.res_valid = 1'($urandom);
    dif.data1     = 16'($urandom);
    dif.data2     = 16'($urandom);
    dif.data3     = $urandom;
    ticks(2);
    chk("rst_sel",  32'(dif.sel), 32'd0);
    chk("rst_led",  32'(dif.led), 32'd1);
    chk("rst_out",  dif.out, 32'd0);
    chk("rst_hold", 32'(dif.hold_active), 32'd0);

    rst_n = 1'b1; dif.key_mode = 1'b1; dif.res_valid = 1'b0; dif.data1 = 16'h1234;
    tick();
    chk("out_data1", dif.out, 32'h0000_1234);

    // Clean presses: step lands on the 7th edge after the key goes low
    for (int i = 0; i < 3; i++) begin
      dif.key_mode = 1'b0;
      ticks(6);
      chk("pre_step", 32'(dif.sel), 32'(seq[(i + 2) % 3]));
      tick();
      chk("step_at_7", 32'(dif.sel), 32'(seq[i]));
      ticks(13);
      dif.key_mode = 1'b1;
      ticks(20);
      chk("release_no_step", 32'(dif.sel), 32'(seq[i]));
    end

    // Bounce rejected, then one clean press
    dif.key_mode = 1'b0; ticks(3);
    dif.key_mode = 1'b1; tick();
    dif.key_mode = 1'b0; ticks(3);
    dif.key_mode = 1'b1; ticks(10);
    chk("bounce_no_step", 32'(dif.sel), 32'd0);
    press(10, 10);
    chk("one_step", 32'(dif.sel), 32'd1);

    // Forced result display from SHOW_B
    dif.data2 = 16'hBEEF; dif.data3 = 32'hCAFE_F00D; dif.res_valid = 1'b1;
    tick();
    dif.res_valid = 1'b0; dif.data3 = $urandom;
    chk("hold_rise", 32'(dif.hold_active), 32'd1);
    tick();
    chk("hold_out", dif.out, 32'hCAFE_F00D);
    ticks(6);
    chk("hold_last", 32'(dif.hold_active), 32'd1);
    dif.data3 = $urandom;
    tick();
    chk("hold_return_sel", 32'(dif.sel), 32'd1);
    chk("hold_return_flag", 32'(dif.hold_active), 32'd0);
    tick();
    chk("return_out", dif.out, 32'h0000_BEEF);

    // Retrigger at hold cycle 5
    dif.data3 = 32'hCAFE_F00D; dif.res_valid = 1'b1;
    tick();
    dif.res_valid = 1'b0;
    ticks(4);
    dif.data3 = 32'h0000_0042; dif.res_valid = 1'b1;
    tick();
    dif.res_valid = 1'b0;
    tick();
    chk("retrig_out", dif.out, 32'h0000_0042);
    ticks(6);
    chk("retrig_still_hold", 32'(dif.hold_active), 32'd1);
    tick();
    chk("retrig_return", 32'(dif.sel), 32'd1);

    // Result pulse coinciding with a press event
    dif.key_mode = 1'b0;
    k = 0;
    while (!m_press && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 20) begin
      errors++;
      $display("FAIL collision_wait: observed timeout expected press within 20 cycles");
    end
    dif.res_valid = 1'b1; dif.data3 = $urandom;
    tick();
    dif.res_valid = 1'b0; dif.key_mode = 1'b1;
    chk("collision_hold", 32'(dif.hold_active), 32'd1);
    ticks(8);
    chk("collision_press_lost", 32'(dif.sel), 32'd1);

    // Reset mid-hold and mid-debounce
    dif.res_valid = 1'b1; dif.data3 = $urandom;
    tick();
    dif.res_valid = 1'b0; dif.key_mode = 1'b0;
    ticks(2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; dif.key_mode = 1'b1;
    chk("mid_rst_sel",  32'(dif.sel), 32'd0);
    chk("mid_rst_led",  32'(dif.led), 32'd1);
    chk("mid_rst_out",  dif.out, 32'd0);
    chk("mid_rst_hold", 32'(dif.hold_active), 32'd0);
    ticks(10);
    chk("no_partial_press", 32'(dif.sel), 32'd0);
    press(10, 10);
    chk("fresh_press", 32'(dif.sel), 32'd1);

    // Random traffic
    hold_len = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold_len == 0) begin
        dif.key_mode = 1'($urandom_range(0, 1));
        hold_len = $urandom_range(1, 12);
      end
      hold_len--;
      dif.res_valid = ($urandom_range(0, 19) == 0);
      dif.data1 = 16'($urandom);
      dif.data2 = 16'($urandom);
      dif.data3 = $urandom;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
